// File: rtl/hex_frame_arbiter.sv
// hex_frame_arbiter
// Hands ownership of a hex/OLED display between two requesters (A and B).
// Ownership and the displayed data word only change at a frame boundary.
// A boundary is the scan position re-entering (0,0) from any other position.
// An owner that still requests keeps the display for at least C_min_frames
// frames before the other requester may take it over.
//
// Build option: define HEX_ARB_BLANK_EN to blank the data word (all zero)
// whenever a boundary leaves the arbiter idle. Without it, the last word is
// held while idle.
module hex_frame_arbiter #(
    parameter int C_data_len   = 128,
    parameter int C_x_size     = 128,
    parameter int C_y_size     = 64,
    parameter int C_min_frames = 4      // 1..255
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          req_a_i,
    input  logic                          req_b_i,
    input  logic [C_data_len-1:0]         data_a_i,
    input  logic [C_data_len-1:0]         data_b_i,
    input  logic [$clog2(C_x_size)-1:0]   x_i,
    input  logic [$clog2(C_y_size)-1:0]   y_i,
    output logic                          grant_a_o,
    output logic                          grant_b_o,
    output logic [C_data_len-1:0]         data_o,
    output logic                          frame_tick_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN_A = 2'd1,
        ST_OWN_B = 2'd2
    } state_t;

    // The counter saturates at C_min_frames, which fits in 8 bits for 1..255.
    localparam logic [7:0] MIN_F  = 8'(C_min_frames);
    localparam logic [7:0] MIN_M1 = 8'(C_min_frames - 1);

    state_t                       state_q, state_d, arb_next;
    logic [7:0]                   cnt_q, cnt_d;
    logic [C_data_len-1:0]        data_q, data_d;
    logic                         tick_q, tick_d;
    logic                         last_b_q, last_b_d;   // 1: last owner was B
    logic [$clog2(C_x_size)-1:0]  x_prev_q;
    logic [$clog2(C_y_size)-1:0]  y_prev_q;

    logic at_origin;
    logic prev_origin;
    logic boundary;
    logic hold_done;

    // Boundary: now at (0,0) while the previous cycle was elsewhere, so a
    // scan parked at (0,0) yields a single boundary. The previous position
    // resets to (0,0), forcing the scan to leave and re-enter after reset.
    assign at_origin   = (x_i == '0) && (y_i == '0);
    assign prev_origin = (x_prev_q == '0) && (y_prev_q == '0);
    assign boundary    = at_origin && !prev_origin;

    // cnt_q counts frames completed before the current one; the frame that
    // ends at this boundary also counts, hence the comparison with min-1.
    assign hold_done = (cnt_q >= MIN_M1);

    // Track the previous scan position every cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_prev_q <= '0;
            y_prev_q <= '0;
        end else begin
            x_prev_q <= x_i;
            y_prev_q <= y_i;
        end
    end

    // Arbitration decision: the owner for the next frame, assuming a boundary.
    always_comb begin
        arb_next = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_a_i && req_b_i) begin
                    arb_next = last_b_q ? ST_OWN_A : ST_OWN_B;
                end else if (req_a_i) begin
                    arb_next = ST_OWN_A;
                end else if (req_b_i) begin
                    arb_next = ST_OWN_B;
                end else begin
                    arb_next = ST_IDLE;
                end
            end
            ST_OWN_A: begin
                if (!req_a_i) begin
                    arb_next = req_b_i ? ST_OWN_B : ST_IDLE;
                end else if (req_b_i && hold_done) begin
                    arb_next = ST_OWN_B;
                end else begin
                    arb_next = ST_OWN_A;
                end
            end
            ST_OWN_B: begin
                if (!req_b_i) begin
                    arb_next = req_a_i ? ST_OWN_A : ST_IDLE;
                end else if (req_a_i && hold_done) begin
                    arb_next = ST_OWN_A;
                end else begin
                    arb_next = ST_OWN_B;
                end
            end
            default: arb_next = ST_IDLE;
        endcase
    end

    // Next-state and output update, applied only when a boundary is seen.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        last_b_d = last_b_q;
        tick_d   = 1'b0;
        if (boundary) begin
            tick_d  = 1'b1;
            state_d = arb_next;
            // Ownership changes restart the hold count; a kept owner
            // accumulates frames up to the saturation value.
            if (arb_next != state_q) begin
                cnt_d = 8'd0;
            end else if (arb_next != ST_IDLE && cnt_q < MIN_F) begin
                cnt_d = cnt_q + 8'd1;
            end
            case (arb_next)
                ST_OWN_A: begin
                    data_d   = data_a_i;
                    last_b_d = 1'b0;
                end
                ST_OWN_B: begin
                    data_d   = data_b_i;
                    last_b_d = 1'b1;
                end
                default: begin
`ifdef HEX_ARB_BLANK_EN
                    data_d = '0;
`else
                    data_d = data_q;
`endif
                end
            endcase
        end
    end

    // State, counter and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 8'd0;
            data_q   <= '0;
            tick_q   <= 1'b0;
            last_b_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            tick_q   <= tick_d;
            last_b_q <= last_b_d;
        end
    end

    assign grant_a_o    = (state_q == ST_OWN_A);
    assign grant_b_o    = (state_q == ST_OWN_B);
    assign data_o       = data_q;
    assign frame_tick_o = tick_q;

endmodule
